// File: rtl/bus_mem_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : bus_mem_datapath
//  Purpose  : Shared-bus datapath core. A general register file, MAR and MDR
//             sit on one priority-resolved combinational bus, and any cycle
//             with several drivers is flagged. A handshaked memory transfer
//             engine with a timeout moves data between MDR and memory.
//  Ports    : clock, clear (async active-low)
//             reg_out/reg_in   per-register bus drive / load enables
//             ext_out/ext_data external bus source
//             mdr_out, mar_in, mdr_in  MAR/MDR bus strobes
//             rd_start/wr_start, err_clr  control pulses
//             bus              resolved bus value (combinational)
//             mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack  memory port
//             busy, done, err_timeout, err_contention  status
//  Revision : 1.0  initial release
// ============================================================================
module bus_mem_datapath #(
    parameter int WIDTH   = 32,
    parameter int NREG    = 16,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15,
    parameter int ZERO_R0 = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [NREG-1:0]   reg_out,
    input  logic [NREG-1:0]   reg_in,
    input  logic              ext_out,
    input  logic [WIDTH-1:0]  ext_data,
    input  logic              mdr_out,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              rd_start,
    input  logic              wr_start,
    input  logic              err_clr,
    output logic [WIDTH-1:0]  bus,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              err_contention
);

    localparam logic [NREG-1:0] c_ONE     = NREG'(1);
    localparam logic [7:0]      c_TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_cnt;
    logic [7:0]         w_cnt_nxt;
    logic               w_start;
    logic               w_timeout_evt;
    logic               w_capture;

    logic [WIDTH-1:0]   r_regs [NREG];
    logic [WIDTH-1:0]   w_src  [NREG];
    logic [ADDR_W-1:0]  r_mar;
    logic [WIDTH-1:0]   r_mdr;
    logic [ADDR_W-1:0]  r_sh_addr;
    logic [WIDTH-1:0]   r_sh_data;
    logic               r_we;
    logic               r_err_to;
    logic               r_err_cont;

    logic [WIDTH-1:0]   w_bus;
    logic               w_reg_multi;
    logic               w_contention;

    // ------------------------------------------------------------------
    // Register source values; R0 can be hard-wired to read as zero while
    // still holding whatever was loaded into it.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_src
            if (ZERO_R0 != 0 && gi == 0) begin : g_zero
                assign w_src[gi] = '0;
            end else begin : g_reg
                assign w_src[gi] = r_regs[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Bus resolution. Assignments run from lowest to highest priority so
    // the last one taken wins: MDR, then external, then registers from the
    // top index down, leaving the lowest asserted register in control.
    // ------------------------------------------------------------------
    always_comb begin
        w_bus = '0;
        if (mdr_out) w_bus = r_mdr;
        if (ext_out) w_bus = ext_data;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (reg_out[i]) w_bus = w_src[i];
        end
    end

    assign bus = w_bus;

    // x & (x-1) is nonzero exactly when x has two or more bits set.
    assign w_reg_multi  = |(reg_out & (reg_out - c_ONE));
    assign w_contention = w_reg_multi
                        | ((|reg_out) & (ext_out | mdr_out))
                        | (ext_out & mdr_out);

    // ------------------------------------------------------------------
    // Datapath registers. Memory read capture takes precedence over a
    // simultaneous bus load of MDR.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_mar <= '0;
            r_mdr <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (reg_in[i]) r_regs[i] <= w_bus;
            end
            if (mar_in) r_mar <= w_bus[ADDR_W-1:0];
            if (w_capture) begin
                r_mdr <= mem_rdata;
            end else if (mdr_in) begin
                r_mdr <= w_bus;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory transfer engine: next state and outputs.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_start       = 1'b0;
        w_timeout_evt = 1'b0;
        w_capture     = 1'b0;
        mem_req       = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (rd_start || wr_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_ack) begin
                    w_capture   = ~r_we;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == c_TO_LAST) begin
                    // The cycle ending now is the TIMEOUT-th without an ack.
                    w_timeout_evt = 1'b1;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                busy        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_sh_addr  <= '0;
            r_sh_data  <= '0;
            r_err_to   <= 1'b0;
            r_err_cont <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_start) begin
                // Read wins when both starts arrive together.
                r_we      <= ~rd_start;
                r_sh_addr <= r_mar;
                r_sh_data <= r_mdr;
            end
            // A new error event beats a same-cycle clear.
            r_err_to   <= (r_err_to   & ~err_clr) | w_timeout_evt;
            r_err_cont <= (r_err_cont & ~err_clr) | w_contention;
        end
    end

    // During a transfer the port shows the snapshot taken at start, so MAR
    // and MDR may be reloaded freely while the memory is still working.
    assign mem_addr       = (r_state == S_IDLE) ? r_mar : r_sh_addr;
    assign mem_wdata      = (r_state == S_IDLE) ? r_mdr : r_sh_data;
    assign mem_we         = r_we & (r_state == S_REQ);
    assign err_timeout    = r_err_to;
    assign err_contention = r_err_cont;

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_mem_datapath
//  Purpose  : Self-checking bench for bus_mem_datapath. A stimulus process
//             steps a transaction-level model and queues expectations; a
//             monitor and a memory responder pop and compare them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_mem_datapath;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int AW = 9;
    localparam int TO = 15;

    logic          clock = 1'b0;
    logic          clear;
    logic [N-1:0]  reg_out, reg_in;
    logic          ext_out, mdr_out, mar_in, mdr_in;
    logic [W-1:0]  ext_data;
    logic          rd_start, wr_start, err_clr;
    logic [W-1:0]  bus;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata, mem_rdata;
    logic          busy, done, err_timeout, err_contention;

    always #5 clock = ~clock;

    bus_mem_datapath #(
        .WIDTH(W), .NREG(N), .ADDR_W(AW), .TIMEOUT(TO), .ZERO_R0(1)
    ) dut (
        .clock(clock), .clear(clear),
        .reg_out(reg_out), .reg_in(reg_in),
        .ext_out(ext_out), .ext_data(ext_data),
        .mdr_out(mdr_out), .mar_in(mar_in), .mdr_in(mdr_in),
        .rd_start(rd_start), .wr_start(wr_start), .err_clr(err_clr),
        .bus(bus),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .done(done),
        .err_timeout(err_timeout), .err_contention(err_contention)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] ro, ri;
        logic         eo, mo, mai, mdi, rs, ws, clr;
        logic [W-1:0] ed, rd;
        int           lat;
    } stim_t;

    typedef struct { logic [W-1:0] bus; logic cont, to, req, dn, bsy; } cyc_t;
    typedef struct { logic we; logic [AW-1:0] addr; logic [W-1:0] wdata, rdata; int lat; } resp_t;
    typedef struct { int unsigned cyc; logic to; } xfer_t;

    cyc_t  q_cyc[$];
    resp_t q_resp[$];
    xfer_t q_xfer[$];

    // Reference model state
    logic [W-1:0]  m_reg [N];
    logic [AW-1:0] m_mar;
    logic [W-1:0]  m_mdr;
    logic          m_cont, m_to;
    int            m_phase;   // 0 idle, 1 waiting on memory, 2 done cycle
    int            m_rem;
    logic          m_xwe, m_xok;
    logic [W-1:0]  m_xrd;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_reg[i] = '0;
        m_mar = '0; m_mdr = '0; m_cont = 1'b0; m_to = 1'b0;
        m_phase = 0; m_rem = 0; m_xwe = 1'b0; m_xok = 1'b0; m_xrd = '0;
    endtask

    function automatic stim_t idle_stim();
        stim_t s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s = idle_stim();
        if ($urandom_range(0, 1) == 1) s.ro[$urandom_range(0, N-1)] = 1'b1;
        if ($urandom_range(0, 9) == 0) s.ro[$urandom_range(0, N-1)] = 1'b1;
        s.eo  = ($urandom_range(0, 9) < 3);
        s.ed  = $urandom;
        s.mo  = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 2) == 0) s.ri[$urandom_range(0, N-1)] = 1'b1;
        if ($urandom_range(0, 4) == 0) s.ri[$urandom_range(0, N-1)] = 1'b1;
        s.mai = ($urandom_range(0, 6) == 0);
        s.mdi = ($urandom_range(0, 6) == 0);
        s.clr = ($urandom_range(0, 9) == 0);
        s.rs  = ($urandom_range(0, 11) == 0);
        s.ws  = ($urandom_range(0, 11) == 0);
        s.lat = $urandom_range(0, 18);
        s.rd  = $urandom;
        return s;
    endfunction

    // One clock of stimulus: drive, queue expectations, advance the model.
    task automatic step(input stim_t s);
        logic [W-1:0] b;
        bit           found, start, to_evt;
        int           nd, k;
        reg_out = s.ro; reg_in = s.ri; ext_out = s.eo; ext_data = s.ed;
        mdr_out = s.mo; mar_in = s.mai; mdr_in = s.mdi;
        rd_start = s.rs; wr_start = s.ws; err_clr = s.clr;

        found = 0; b = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && s.ro[i]) begin
                b = (i == 0) ? '0 : m_reg[i];
                found = 1;
            end
        end
        if (!found) begin
            if (s.eo)      b = s.ed;
            else if (s.mo) b = m_mdr;
        end
        nd = $countones(s.ro) + int'(s.eo) + int'(s.mo);
        q_cyc.push_back('{b, m_cont, m_to, m_phase == 1, m_phase == 2, m_phase != 0});

        start = (m_phase == 0) && (s.rs || s.ws);
        k = (s.lat < TO) ? s.lat + 1 : TO;
        if (start) begin
            q_resp.push_back('{!s.rs, m_mar, m_mdr, s.rd, s.lat});
            q_xfer.push_back('{cyc + 1 + k, s.lat >= TO});
        end

        @(posedge clock);
        to_evt = 0;
        for (int i = 0; i < N; i++) if (s.ri[i]) m_reg[i] = b;
        if (s.mai) m_mar = b[AW-1:0];
        if (s.mdi) m_mdr = b;
        case (m_phase)
            0: if (start) begin
                m_phase = 1; m_rem = k; m_xwe = !s.rs;
                m_xok = (s.lat < TO); m_xrd = s.rd;
            end
            1: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_phase = 2;
                    if (m_xok && !m_xwe) m_mdr = m_xrd;
                    if (!m_xok) to_evt = 1;
                end
            end
            default: m_phase = 0;
        endcase
        m_cont = (m_cont && !s.clr) || (nd > 1);
        m_to   = (m_to && !s.clr) || to_evt;
        #1;
    endtask

    task automatic finish_xfer();
        int g = 0;
        while (m_phase != 0 && g < 40) begin
            step(idle_stim());
            g++;
        end
    endtask

    // Per-cycle monitor and done-pulse scoreboard
    initial begin
        cyc_t  r;
        xfer_t x;
        forever begin
            @(negedge clock);
            if (q_cyc.size() > 0) begin
                r = q_cyc.pop_front();
                chk("bus", bus, r.bus);
                chk("err_contention", W'(err_contention), W'(r.cont));
                chk("err_timeout", W'(err_timeout), W'(r.to));
                chk("mem_req", W'(mem_req), W'(r.req));
                chk("done", W'(done), W'(r.dn));
                chk("busy", W'(busy), W'(r.bsy));
            end
            if (done === 1'b1) begin
                if (q_xfer.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL done_unexpected at cycle %0d: got done=1, expected no transfer", cyc);
                end else begin
                    x = q_xfer.pop_front();
                    chk("done_cycle", W'(cyc), W'(x.cyc));
                    if (x.to) chk("timeout_at_done", W'(err_timeout), 32'd1);
                end
            end
        end
    end

    // Memory responder: acks after the latency chosen for each transfer
    initial begin
        resp_t rr;
        bit    ract = 0;
        int    rj = 0;
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (mem_req === 1'b1) begin
                if (!ract) begin ract = 1; rj = 0; end
                if (q_resp.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL mem_req_unexpected at cycle %0d: got mem_req=1, expected 0", cyc);
                    mem_ack = 1'b0;
                end else begin
                    rr = q_resp[0];
                    chk("mem_we", W'(mem_we), W'(rr.we));
                    chk("mem_addr", W'(mem_addr), W'(rr.addr));
                    chk("mem_wdata", mem_wdata, rr.wdata);
                    mem_ack   = (rj == rr.lat);
                    mem_rdata = mem_ack ? rr.rdata : W'($urandom);
                end
                rj++;
            end else begin
                if (ract) begin
                    if (q_resp.size() > 0) void'(q_resp.pop_front());
                    ract = 0;
                end
                mem_ack = 1'b0; mem_rdata = W'($urandom);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        clear = 1'b0;
        reg_out = '0; reg_in = '0; ext_out = 0; ext_data = '0; mdr_out = 0;
        mar_in = 0; mdr_in = 0; rd_start = 0; wr_start = 0; err_clr = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("reset_bus", bus, '0);
        chk("reset_mem_req", W'(mem_req), '0);
        chk("reset_flags", W'({busy, done, err_timeout, err_contention, mem_we}), '0);
        clear = 1'b1;
        @(posedge clock); #1;

        // Register copy R3 -> R7, then empty bus
        s = idle_stim(); s.eo = 1; s.ed = 32'h1234_5678; s.ri[3] = 1; step(s);
        s = idle_stim(); s.ro[3] = 1; s.ri[7] = 1; step(s);
        s = idle_stim(); s.ro[7] = 1; step(s);
        step(idle_stim());

        // R0 reads as zero; contention then clear
        s = idle_stim(); s.eo = 1; s.ed = 32'hFFFF_FFFF; s.ri[0] = 1; step(s);
        s = idle_stim(); s.ro[0] = 1; step(s);
        s = idle_stim(); s.eo = 1; s.ed = 32'hCAFE_0002; s.ri[2] = 1; step(s);
        s = idle_stim(); s.ro[2] = 1; s.eo = 1; s.ed = 32'h5555_AAAA; step(s);
        s = idle_stim(); s.clr = 1; step(s);
        step(idle_stim());

        // Read from 0x05A, ack on the fourth REQ cycle
        s = idle_stim(); s.eo = 1; s.ed = 32'h0000_005A; s.mai = 1; step(s);
        s = idle_stim(); s.rs = 1; s.lat = 3; s.rd = 32'hDEAD_BEEF; step(s);
        finish_xfer();
        s = idle_stim(); s.mo = 1; step(s);

        // Write 0xAB to 0x1FF, MDR overwritten while the transfer runs
        s = idle_stim(); s.eo = 1; s.ed = 32'h0000_00AB; s.mdi = 1; step(s);
        s = idle_stim(); s.eo = 1; s.ed = 32'h0000_01FF; s.mai = 1; step(s);
        s = idle_stim(); s.ws = 1; s.lat = 4; step(s);
        s = idle_stim(); s.eo = 1; s.ed = 32'h1111_2222; s.mdi = 1; s.mai = 1; step(s);
        finish_xfer();

        // Boundaries: ack on the last allowed cycle, and immediate ack
        s = idle_stim(); s.rs = 1; s.lat = TO - 1; s.rd = 32'h0BAD_F00D; step(s);
        finish_xfer();
        s = idle_stim(); s.ws = 1; s.lat = 0; step(s);
        finish_xfer();

        // Timeout with a start issued while busy
        s = idle_stim(); s.rs = 1; s.lat = 100; step(s);
        s = idle_stim(); s.rs = 1; s.lat = 0; step(s);
        finish_xfer();
        s = idle_stim(); s.mo = 1; step(s);
        s = idle_stim(); s.clr = 1; step(s);

        // Randomized traffic
        for (int n = 0; n < 600; n++) step(rnd_stim());
        finish_xfer();

        // Reset in the middle of a request
        s = idle_stim(); s.rs = 1; s.lat = 100; step(s);
        repeat (3) step(idle_stim());
        #2;
        clear = 1'b0;
        #1;
        chk("abort_mem_req", W'(mem_req), '0);
        chk("abort_busy", W'(busy), '0);
        if (q_xfer.size() > 0) void'(q_xfer.pop_back());
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b1;
        model_reset();
        @(posedge clock); #1;
        chk("post_reset_mem_addr", W'(mem_addr), '0);
        for (int i = 0; i < N; i++) begin
            s = idle_stim(); s.ro[i] = 1'b1; step(s);
        end
        s = idle_stim(); s.mo = 1; step(s);
        repeat (3) step(idle_stim());
        @(negedge clock);
        chk("xfer_queue_empty", W'(q_xfer.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
